// File: rtl/pipe_ctrl_if.sv
// Boundary bundle between pipe_ctrl and the fetch/decode/execute/memory/writeback stages.
interface pipe_ctrl_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned INST_WIDTH     = 8,
    parameter int unsigned REG_ADDR_WIDTH = 2,
    parameter int unsigned CTL_WIDTH      = 6
);
    // fetch side
    logic [ADDR_WIDTH-1:0]     inst_addr_if;
    logic [INST_WIDTH-1:0]     inst_if;
    logic                      pc_hold;
    // IF/ID and decode side
    logic [ADDR_WIDTH-1:0]     inst_addr_id;
    logic [INST_WIDTH-1:0]     inst_id;
    logic [CTL_WIDTH-1:0]      ctl_id;
    logic                      reg_we_id;
    logic                      mem_re_id;
    logic                      jump_id;
    logic [REG_ADDR_WIDTH-1:0] rs1_id;
    logic [REG_ADDR_WIDTH-1:0] rs2_id;
    logic [REG_ADDR_WIDTH-1:0] dst_reg_id;
    logic                      rs1_used_id;
    logic                      rs2_used_id;
    logic [DATA_WIDTH-1:0]     r1_val_id;
    logic [DATA_WIDTH-1:0]     r2_val_id;
    logic [DATA_WIDTH-1:0]     imm_id;
    // ID/EX and execute side
    logic [CTL_WIDTH-1:0]      ctl_ex;
    logic [ADDR_WIDTH-1:0]     inst_addr_ex;
    logic [DATA_WIDTH-1:0]     imm_ex;
    logic                      jump_ex;
    logic [DATA_WIDTH-1:0]     r1_ex;
    logic [DATA_WIDTH-1:0]     r2_ex;
    logic [DATA_WIDTH-1:0]     alu_out_ex;
    logic [ADDR_WIDTH-1:0]     jump_addr_ex;
    // EX/MA and memory side
    logic [CTL_WIDTH-1:0]      ctl_ma;
    logic                      mem_re_ma;
    logic [DATA_WIDTH-1:0]     alu_out_ma;
    logic                      jump_flag_ma;
    logic [ADDR_WIDTH-1:0]     jump_addr_ma;
    logic [DATA_WIDTH-1:0]     load_val_ma;
    // MA/WB and writeback side
    logic                      reg_we_wb;
    logic [REG_ADDR_WIDTH-1:0] dst_reg_wb;
    logic [DATA_WIDTH-1:0]     data_wb;

    // master: the surrounding core stages
    modport master (
        output inst_addr_if, inst_if,
        output ctl_id, reg_we_id, mem_re_id, jump_id, rs1_id, rs2_id, dst_reg_id,
        output rs1_used_id, rs2_used_id, r1_val_id, r2_val_id, imm_id,
        output alu_out_ex, jump_addr_ex, load_val_ma,
        input  pc_hold, inst_addr_id, inst_id,
        input  ctl_ex, inst_addr_ex, imm_ex, jump_ex, r1_ex, r2_ex,
        input  ctl_ma, mem_re_ma, alu_out_ma, jump_flag_ma, jump_addr_ma,
        input  reg_we_wb, dst_reg_wb, data_wb
    );

    // slave: pipe_ctrl itself
    modport slave (
        input  inst_addr_if, inst_if,
        input  ctl_id, reg_we_id, mem_re_id, jump_id, rs1_id, rs2_id, dst_reg_id,
        input  rs1_used_id, rs2_used_id, r1_val_id, r2_val_id, imm_id,
        input  alu_out_ex, jump_addr_ex, load_val_ma,
        output pc_hold, inst_addr_id, inst_id,
        output ctl_ex, inst_addr_ex, imm_ex, jump_ex, r1_ex, r2_ex,
        output ctl_ma, mem_re_ma, alu_out_ma, jump_flag_ma, jump_addr_ma,
        output reg_we_wb, dst_reg_wb, data_wb
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline boundary registers plus hazard detection, stall, flush and forwarding for the 5-stage core.
// Optional feature: define PIPE_FWD_EN to forward MA/WB results into EX (only load-use then stalls).
module pipe_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned INST_WIDTH     = 8,
    parameter int unsigned REG_ADDR_WIDTH = 2,
    parameter int unsigned CTL_WIDTH      = 6
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    pipe_ctrl_if.slave  bus
);

    // IF/ID
    logic                      r_valid_id;
    logic [ADDR_WIDTH-1:0]     r_inst_addr_id;
    logic [INST_WIDTH-1:0]     r_inst_id;
    // ID/EX
    logic                      r_valid_ex;
    logic [CTL_WIDTH-1:0]      r_ctl_ex;
    logic [ADDR_WIDTH-1:0]     r_inst_addr_ex;
    logic [DATA_WIDTH-1:0]     r_imm_ex;
    logic                      r_jump_ex;
    logic                      r_reg_we_ex;
    logic                      r_mem_re_ex;
    logic [REG_ADDR_WIDTH-1:0] r_dst_ex;
    logic [DATA_WIDTH-1:0]     r_r1_ex;
    logic [DATA_WIDTH-1:0]     r_r2_ex;
`ifdef PIPE_FWD_EN
    logic [REG_ADDR_WIDTH-1:0] r_rs1_ex;
    logic [REG_ADDR_WIDTH-1:0] r_rs2_ex;
    logic                      r_rs1_used_ex;
    logic                      r_rs2_used_ex;
`endif
    // EX/MA
    logic                      r_valid_ma;
    logic [CTL_WIDTH-1:0]      r_ctl_ma;
    logic                      r_reg_we_ma;
    logic                      r_mem_re_ma;
    logic [REG_ADDR_WIDTH-1:0] r_dst_ma;
    logic [DATA_WIDTH-1:0]     r_alu_out_ma;
    logic                      r_jump_flag_ma;
    logic [ADDR_WIDTH-1:0]     r_jump_addr_ma;
    // MA/WB
    logic                      r_valid_wb;
    logic                      r_reg_we_wb;
    logic                      r_mem_re_wb;
    logic [REG_ADDR_WIDTH-1:0] r_dst_wb;
    logic [DATA_WIDTH-1:0]     r_alu_out_wb;

    logic                      w_flush;
    logic                      w_stall;
    logic                      w_m1_ex, w_m2_ex, w_m1_ma, w_m2_ma;
    logic [DATA_WIDTH-1:0]     w_data_wb;
    logic [DATA_WIDTH-1:0]     w_r1_cap;
    logic [DATA_WIDTH-1:0]     w_r2_cap;
    logic [DATA_WIDTH-1:0]     w_r1_ex;
    logic [DATA_WIDTH-1:0]     w_r2_ex;

    assign w_flush   = r_jump_flag_ma;
    assign w_data_wb = r_mem_re_wb ? bus.load_val_ma : r_alu_out_wb;

    // RAW matches of the instruction in ID against producers in EX and MA
    assign w_m1_ex = r_valid_ex & r_reg_we_ex & (r_dst_ex == bus.rs1_id) & bus.rs1_used_id;
    assign w_m2_ex = r_valid_ex & r_reg_we_ex & (r_dst_ex == bus.rs2_id) & bus.rs2_used_id;
    assign w_m1_ma = r_valid_ma & r_reg_we_ma & (r_dst_ma == bus.rs1_id) & bus.rs1_used_id;
    assign w_m2_ma = r_valid_ma & r_reg_we_ma & (r_dst_ma == bus.rs2_id) & bus.rs2_used_id;

`ifdef PIPE_FWD_EN
    // ALU results are forwarded, so only a load still in flight forces a wait
    assign w_stall = r_valid_id & ((r_mem_re_ex & (w_m1_ex | w_m2_ex)) |
                                   (r_mem_re_ma & (w_m1_ma | w_m2_ma)));
`else
    assign w_stall = r_valid_id & (w_m1_ex | w_m2_ex | w_m1_ma | w_m2_ma);
`endif

    // Flush and reset release the PC so fetch can redirect immediately
    assign bus.pc_hold = w_stall & ~w_flush & ~sys_rst;

    // Regfile write and read in the same cycle: take the value being written
    assign w_r1_cap = (r_valid_wb & r_reg_we_wb & (r_dst_wb == bus.rs1_id)) ? w_data_wb : bus.r1_val_id;
    assign w_r2_cap = (r_valid_wb & r_reg_we_wb & (r_dst_wb == bus.rs2_id)) ? w_data_wb : bus.r2_val_id;

`ifdef PIPE_FWD_EN
    logic w_f1_ma, w_f2_ma, w_f1_wb, w_f2_wb;

    // A load in MA has no data yet; it is covered by the load-use stall instead
    assign w_f1_ma = r_valid_ma & r_reg_we_ma & ~r_mem_re_ma & (r_dst_ma == r_rs1_ex) & r_rs1_used_ex;
    assign w_f2_ma = r_valid_ma & r_reg_we_ma & ~r_mem_re_ma & (r_dst_ma == r_rs2_ex) & r_rs2_used_ex;
    assign w_f1_wb = r_valid_wb & r_reg_we_wb & (r_dst_wb == r_rs1_ex) & r_rs1_used_ex;
    assign w_f2_wb = r_valid_wb & r_reg_we_wb & (r_dst_wb == r_rs2_ex) & r_rs2_used_ex;

    always_comb begin
        w_r1_ex = r_r1_ex;
        w_r2_ex = r_r2_ex;
        if (w_f1_ma)      w_r1_ex = r_alu_out_ma;
        else if (w_f1_wb) w_r1_ex = w_data_wb;
        if (w_f2_ma)      w_r2_ex = r_alu_out_ma;
        else if (w_f2_wb) w_r2_ex = w_data_wb;
    end
`else
    always_comb begin
        w_r1_ex = r_r1_ex;
        w_r2_ex = r_r2_ex;
    end
`endif

    // IF/ID: bubble on flush, hold on stall
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_flush) begin
            r_valid_id     <= 1'b0;
            r_inst_addr_id <= '0;
            r_inst_id      <= '0;
        end else if (!w_stall) begin
            r_valid_id     <= 1'b1;
            r_inst_addr_id <= bus.inst_addr_if;
            r_inst_id      <= bus.inst_if;
        end
    end

    // ID/EX: a stalled or invalid ID slot enters EX as a bubble
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_flush || w_stall || !r_valid_id) begin
            r_valid_ex     <= 1'b0;
            r_ctl_ex       <= '0;
            r_inst_addr_ex <= '0;
            r_imm_ex       <= '0;
            r_jump_ex      <= 1'b0;
            r_reg_we_ex    <= 1'b0;
            r_mem_re_ex    <= 1'b0;
            r_dst_ex       <= '0;
            r_r1_ex        <= '0;
            r_r2_ex        <= '0;
`ifdef PIPE_FWD_EN
            r_rs1_ex       <= '0;
            r_rs2_ex       <= '0;
            r_rs1_used_ex  <= 1'b0;
            r_rs2_used_ex  <= 1'b0;
`endif
        end else begin
            r_valid_ex     <= 1'b1;
            r_ctl_ex       <= bus.ctl_id;
            r_inst_addr_ex <= r_inst_addr_id;
            r_imm_ex       <= bus.imm_id;
            r_jump_ex      <= bus.jump_id;
            r_reg_we_ex    <= bus.reg_we_id;
            r_mem_re_ex    <= bus.mem_re_id;
            r_dst_ex       <= bus.dst_reg_id;
            r_r1_ex        <= w_r1_cap;
            r_r2_ex        <= w_r2_cap;
`ifdef PIPE_FWD_EN
            r_rs1_ex       <= bus.rs1_id;
            r_rs2_ex       <= bus.rs2_id;
            r_rs1_used_ex  <= bus.rs1_used_id;
            r_rs2_used_ex  <= bus.rs2_used_id;
`endif
        end
    end

    // EX/MA: never stalls; the wrong-path instruction in EX is dropped on flush
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_flush || !r_valid_ex) begin
            r_valid_ma     <= 1'b0;
            r_ctl_ma       <= '0;
            r_reg_we_ma    <= 1'b0;
            r_mem_re_ma    <= 1'b0;
            r_dst_ma       <= '0;
            r_alu_out_ma   <= '0;
            r_jump_flag_ma <= 1'b0;
            r_jump_addr_ma <= '0;
        end else begin
            r_valid_ma     <= 1'b1;
            r_ctl_ma       <= r_ctl_ex;
            r_reg_we_ma    <= r_reg_we_ex;
            r_mem_re_ma    <= r_mem_re_ex;
            r_dst_ma       <= r_dst_ex;
            r_alu_out_ma   <= bus.alu_out_ex;
            r_jump_flag_ma <= r_jump_ex;
            r_jump_addr_ma <= bus.jump_addr_ex;
        end
    end

    // MA/WB: the jump itself retires normally, so this stage ignores flush
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !r_valid_ma) begin
            r_valid_wb   <= 1'b0;
            r_reg_we_wb  <= 1'b0;
            r_mem_re_wb  <= 1'b0;
            r_dst_wb     <= '0;
            r_alu_out_wb <= '0;
        end else begin
            r_valid_wb   <= 1'b1;
            r_reg_we_wb  <= r_reg_we_ma;
            r_mem_re_wb  <= r_mem_re_ma;
            r_dst_wb     <= r_dst_ma;
            r_alu_out_wb <= r_alu_out_ma;
        end
    end

    assign bus.inst_addr_id = r_inst_addr_id;
    assign bus.inst_id      = r_inst_id;
    assign bus.ctl_ex       = r_ctl_ex;
    assign bus.inst_addr_ex = r_inst_addr_ex;
    assign bus.imm_ex       = r_imm_ex;
    assign bus.jump_ex      = r_jump_ex;
    assign bus.r1_ex        = w_r1_ex;
    assign bus.r2_ex        = w_r2_ex;
    assign bus.ctl_ma       = r_ctl_ma;
    assign bus.mem_re_ma    = r_mem_re_ma;
    assign bus.alu_out_ma   = r_alu_out_ma;
    assign bus.jump_flag_ma = r_jump_flag_ma;
    assign bus.jump_addr_ma = r_jump_addr_ma;
    assign bus.reg_we_wb    = r_reg_we_wb;
    assign bus.dst_reg_wb   = r_dst_wb;
    assign bus.data_wb      = w_data_wb;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; expectations follow PIPE_FWD_EN when it is defined.
module tb_pipe_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_cmp   = 0;
    int   n_mis   = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_id();
        bus.ctl_id      = '0;
        bus.reg_we_id   = 1'b0;
        bus.mem_re_id   = 1'b0;
        bus.jump_id     = 1'b0;
        bus.rs1_id      = '0;
        bus.rs2_id      = '0;
        bus.dst_reg_id  = '0;
        bus.rs1_used_id = 1'b0;
        bus.rs2_used_id = 1'b0;
        bus.r1_val_id   = '0;
        bus.r2_val_id   = '0;
        bus.imm_id      = '0;
    endtask

    task automatic rand_in();
        bus.inst_addr_if = 4'($urandom);
        bus.inst_if      = 8'($urandom);
        bus.ctl_id       = 6'($urandom);
        bus.reg_we_id    = 1'($urandom);
        bus.mem_re_id    = 1'($urandom);
        bus.jump_id      = 1'($urandom);
        bus.rs1_id       = 2'($urandom);
        bus.rs2_id       = 2'($urandom);
        bus.dst_reg_id   = 2'($urandom);
        bus.rs1_used_id  = 1'($urandom);
        bus.rs2_used_id  = 1'($urandom);
        bus.r1_val_id    = 8'($urandom);
        bus.r2_val_id    = 8'($urandom);
        bus.imm_id       = 8'($urandom);
        bus.alu_out_ex   = 8'($urandom);
        bus.jump_addr_ex = 4'($urandom);
        bus.load_val_ma  = 8'($urandom);
    endtask

    task automatic drain();
        clr_id();
        bus.alu_out_ex   = '0;
        bus.jump_addr_ex = '0;
        bus.load_val_ma  = '0;
        bus.inst_if      = 8'h5A;
        bus.inst_addr_if = 4'h1;
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rand_in();
        tick();
        rand_in();
        tick();
        rand_in();
        settle();
        chk("rst_pc_hold",  32'(bus.pc_hold), 32'h0);
        chk("rst_inst_id",  32'(bus.inst_id), 32'h0);
        chk("rst_ctl_ex",   32'(bus.ctl_ex), 32'h0);
        chk("rst_r1_ex",    32'(bus.r1_ex), 32'h0);
        chk("rst_r2_ex",    32'(bus.r2_ex), 32'h0);
        chk("rst_ctl_ma",   32'(bus.ctl_ma), 32'h0);
        chk("rst_jflag_ma", 32'(bus.jump_flag_ma), 32'h0);
        chk("rst_reg_we_wb",32'(bus.reg_we_wb), 32'h0);
        chk("rst_data_wb",  32'(bus.data_wb), 32'h0);

        // ---------------- release: IF->ID in one edge ----------------
        sys_rst = 1'b0;
        clr_id();
        bus.alu_out_ex   = '0;
        bus.jump_addr_ex = '0;
        bus.load_val_ma  = '0;
        bus.inst_if      = 8'h5A;
        bus.inst_addr_if = 4'h1;
        tick();
        chk("rel_inst_id",      32'(bus.inst_id), 32'h5A);
        chk("rel_inst_addr_id", 32'(bus.inst_addr_id), 32'h1);

        // ---------------- ADD r1<-3 ; ADD r2<-r1+r1 ----------------
        bus.ctl_id = 6'h11; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd1;
        settle();
        chk("add1_pc_hold", 32'(bus.pc_hold), 32'h0);
        tick();
        chk("add1_ctl_ex", 32'(bus.ctl_ex), 32'h11);
        clr_id();
        bus.ctl_id = 6'h12; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd2;
        bus.rs1_id = 2'd1; bus.rs2_id = 2'd1; bus.rs1_used_id = 1'b1; bus.rs2_used_id = 1'b1;
        bus.alu_out_ex = 8'h03;
        bus.inst_if = 8'hEE;
        settle();
`ifdef PIPE_FWD_EN
        chk("add2_pc_hold", 32'(bus.pc_hold), 32'h0);
        tick();
        chk("add2_alu_out_ma", 32'(bus.alu_out_ma), 32'h03);
        chk("add2_ctl_ex", 32'(bus.ctl_ex), 32'h12);
        chk("add2_r1_ex_fwd", 32'(bus.r1_ex), 32'h03);
        chk("add2_r2_ex_fwd", 32'(bus.r2_ex), 32'h03);
`else
        chk("add2_stall1", 32'(bus.pc_hold), 32'h1);
        tick();
        bus.alu_out_ex = 8'h00;
        settle();
        chk("add2_bubble_ctl_ex", 32'(bus.ctl_ex), 32'h0);
        chk("add2_hold_inst_id", 32'(bus.inst_id), 32'h5A);
        chk("add2_stall2", 32'(bus.pc_hold), 32'h1);
        tick();
        chk("add2_stall_end", 32'(bus.pc_hold), 32'h0);
        chk("add2_data_wb", 32'(bus.data_wb), 32'h03);
        tick();
        chk("add2_ctl_ex", 32'(bus.ctl_ex), 32'h12);
        chk("add2_r1_ex", 32'(bus.r1_ex), 32'h03);
        chk("add2_r2_ex", 32'(bus.r2_ex), 32'h03);
`endif
        drain();

        // ---------------- load-use: LOAD r2 (0x7F) ; use r2 ----------------
        bus.ctl_id = 6'h21; bus.reg_we_id = 1'b1; bus.mem_re_id = 1'b1; bus.dst_reg_id = 2'd2;
        tick();
        clr_id();
        bus.ctl_id = 6'h22; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd3;
        bus.rs1_id = 2'd2; bus.rs1_used_id = 1'b1;
        bus.inst_if = 8'hEE;
        settle();
        chk("ld_stall1", 32'(bus.pc_hold), 32'h1);
        tick();
        chk("ld_mem_re_ma", 32'(bus.mem_re_ma), 32'h1);
        chk("ld_bubble1", 32'(bus.ctl_ex), 32'h0);
        chk("ld_hold_inst_id", 32'(bus.inst_id), 32'h5A);
        chk("ld_stall2", 32'(bus.pc_hold), 32'h1);
        tick();
        bus.load_val_ma = 8'h7F;
        settle();
        chk("ld_stall_end", 32'(bus.pc_hold), 32'h0);
        chk("ld_bubble2", 32'(bus.ctl_ex), 32'h0);
        chk("ld_data_wb", 32'(bus.data_wb), 32'h7F);
        tick();
        bus.load_val_ma = 8'h00;
        settle();
        chk("ld_use_ctl_ex", 32'(bus.ctl_ex), 32'h22);
        chk("ld_use_r1_ex", 32'(bus.r1_ex), 32'h7F);
        chk("ld_next_inst_id", 32'(bus.inst_id), 32'hEE);
        drain();

        // ---------------- taken jump to 0x9 ----------------
        bus.ctl_id = 6'h30; bus.jump_id = 1'b1; bus.inst_addr_if = 4'h4;
        tick();
        chk("jmp_jump_ex", 32'(bus.jump_ex), 32'h1);
        clr_id();
        bus.ctl_id = 6'h3F; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd1;
        bus.jump_addr_ex = 4'h9;
        tick();
        chk("jmp_flag_on", 32'(bus.jump_flag_ma), 32'h1);
        chk("jmp_addr_ma", 32'(bus.jump_addr_ma), 32'h9);
        chk("jmp_w1_ctl_ex", 32'(bus.ctl_ex), 32'h3F);
        clr_id();
        bus.ctl_id = 6'h3E; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd2;
        bus.jump_addr_ex = 4'h0; bus.alu_out_ex = 8'h55;
        settle();
        chk("jmp_pc_hold", 32'(bus.pc_hold), 32'h0);
        tick();
        chk("jmp_flag_off", 32'(bus.jump_flag_ma), 32'h0);
        chk("jmp_flush_ctl_ma", 32'(bus.ctl_ma), 32'h0);
        chk("jmp_flush_ctl_ex", 32'(bus.ctl_ex), 32'h0);
        chk("jmp_flush_inst_id", 32'(bus.inst_id), 32'h0);
        chk("jmp_wb_reg_we", 32'(bus.reg_we_wb), 32'h0);
        bus.inst_addr_if = 4'h9; bus.inst_if = 8'h99; bus.alu_out_ex = 8'h00;
        clr_id();
        bus.ctl_id = 6'h3D; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd3;
        tick();
        chk("jmp_target_addr_id", 32'(bus.inst_addr_id), 32'h9);
        chk("jmp_target_inst_id", 32'(bus.inst_id), 32'h99);
        chk("jmp_slot_ctl_ex", 32'(bus.ctl_ex), 32'h0);
        chk("jmp_slot_ctl_ma", 32'(bus.ctl_ma), 32'h0);
        chk("jmp_slot_reg_we_wb1", 32'(bus.reg_we_wb), 32'h0);
        clr_id();
        bus.ctl_id = 6'h01;
        tick();
        chk("jmp_tgt_ctl_ex", 32'(bus.ctl_ex), 32'h01);
        chk("jmp_slot_ctl_ma2", 32'(bus.ctl_ma), 32'h0);
        chk("jmp_slot_reg_we_wb2", 32'(bus.reg_we_wb), 32'h0);
        drain();

        // ---------------- load-use stall coinciding with jump ----------------
        bus.ctl_id = 6'h30; bus.jump_id = 1'b1;
        tick();
        clr_id();
        bus.ctl_id = 6'h21; bus.reg_we_id = 1'b1; bus.mem_re_id = 1'b1; bus.dst_reg_id = 2'd2;
        bus.jump_addr_ex = 4'hA;
        settle();
        chk("jx_no_stall", 32'(bus.pc_hold), 32'h0);
        tick();
        clr_id();
        bus.ctl_id = 6'h22; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd3;
        bus.rs1_id = 2'd2; bus.rs1_used_id = 1'b1;
        bus.jump_addr_ex = 4'h0;
        settle();
        chk("jx_flag", 32'(bus.jump_flag_ma), 32'h1);
        chk("jx_pc_hold", 32'(bus.pc_hold), 32'h0);
        tick();
        chk("jx_ctl_ex", 32'(bus.ctl_ex), 32'h0);
        chk("jx_ctl_ma", 32'(bus.ctl_ma), 32'h0);
        chk("jx_mem_re_ma", 32'(bus.mem_re_ma), 32'h0);
        chk("jx_inst_id", 32'(bus.inst_id), 32'h0);
        chk("jx_pc_hold_after", 32'(bus.pc_hold), 32'h0);
        tick();
        chk("jx_use_never_ex", 32'(bus.ctl_ex), 32'h0);
        drain();

        // ---------------- same-cycle WB write r3=0xC4, stale read ----------------
        bus.ctl_id = 6'h05; bus.reg_we_id = 1'b1; bus.dst_reg_id = 2'd3;
        tick();
        clr_id();
        bus.alu_out_ex = 8'hC4;
        tick();
        bus.alu_out_ex = 8'h00;
        tick();
        bus.ctl_id = 6'h06; bus.rs1_id = 2'd3; bus.rs1_used_id = 1'b1; bus.r1_val_id = 8'h00;
        settle();
        chk("byp_data_wb", 32'(bus.data_wb), 32'hC4);
        chk("byp_dst_wb", 32'(bus.dst_reg_wb), 32'h3);
        chk("byp_pc_hold", 32'(bus.pc_hold), 32'h0);
        tick();
        chk("byp_ctl_ex", 32'(bus.ctl_ex), 32'h06);
        chk("byp_r1_ex", 32'(bus.r1_ex), 32'hC4);
        drain();

        // ---------------- reset during a load-use stall ----------------
        bus.ctl_id = 6'h21; bus.reg_we_id = 1'b1; bus.mem_re_id = 1'b1; bus.dst_reg_id = 2'd2;
        tick();
        clr_id();
        bus.ctl_id = 6'h22; bus.rs1_id = 2'd2; bus.rs1_used_id = 1'b1;
        settle();
        chk("rs_stall", 32'(bus.pc_hold), 32'h1);
        sys_rst = 1'b1;
        settle();
        chk("rs_pc_hold_drop", 32'(bus.pc_hold), 32'h0);
        tick();
        chk("rs_ctl_ex", 32'(bus.ctl_ex), 32'h0);
        chk("rs_ctl_ma", 32'(bus.ctl_ma), 32'h0);
        chk("rs_mem_re_ma", 32'(bus.mem_re_ma), 32'h0);
        chk("rs_inst_id", 32'(bus.inst_id), 32'h0);
        chk("rs_reg_we_wb", 32'(bus.reg_we_wb), 32'h0);
        sys_rst = 1'b0;
        clr_id();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline-boundary and hazard unit for the five-stage core. It holds the IF/ID, ID/EX, EX/MA and MA/WB registers. It detects RAW and load-use hazards, forwards results into EX, inserts bubbles, stalls fetch, and flushes wrong-path instructions on a taken jump. It sits between `inst_fetch`, `inst_decode`, `execute`, `mem_access` and `write_back`, and replaces the hand-written boundary assignments in the top level.

## Interface
Clocking is fixed: one clock `sys_clk`; `sys_rst` is synchronous, active-high.

Parameters:
- `DATA_WIDTH`, 8, datapath width
- `ADDR_WIDTH`, 4, instruction/data address width
- `INST_WIDTH`, 8, instruction width
- `REG_ADDR_WIDTH`, 2, register index width
- `CTL_WIDTH`, 6, opaque EX/MA control bundle (alu_ctl, alu_src_sel, mem_we, …)

Ports:
- `sys_clk`  in  1  clock
- `sys_rst`  in  1  sync reset, active-high
- `inst_addr_if` / `inst_if`  in  ADDR_WIDTH / INST_WIDTH  fetch outputs
- `pc_hold`  out  1  freeze PC (combinational)
- `inst_addr_id` / `inst_id`  out  ADDR_WIDTH / INST_WIDTH  IF/ID register
- `ctl_id`  in  CTL_WIDTH  decoded control
- `reg_we_id`, `mem_re_id`, `jump_id`  in  1  decoded write-enable, load, jump
- `rs1_id`, `rs2_id`, `dst_reg_id`  in  REG_ADDR_WIDTH  source and destination registers
- `rs1_used_id`, `rs2_used_id`  in  1  source actually read
- `r1_val_id`, `r2_val_id`, `imm_id`  in  DATA_WIDTH  regfile reads and sign-extended immediate
- `ctl_ex`  out  CTL_WIDTH
- `inst_addr_ex`  out  ADDR_WIDTH
- `imm_ex`  out  DATA_WIDTH
- `jump_ex`  out  1
- `r1_ex`, `r2_ex`  out  DATA_WIDTH  forwarded operands (combinational)
- `alu_out_ex`  in  DATA_WIDTH
- `jump_addr_ex`  in  ADDR_WIDTH
- `ctl_ma`  out  CTL_WIDTH
- `mem_re_ma`  out  1
- `alu_out_ma`  out  DATA_WIDTH
- `jump_flag_ma`  out  1
- `jump_addr_ma`  out  ADDR_WIDTH
- `load_val_ma`  in  DATA_WIDTH  registered memory read, valid while the load is in WB
- `reg_we_wb`  out  1
- `dst_reg_wb`  out  REG_ADDR_WIDTH
- `data_wb`  out  DATA_WIDTH  `mem_re_wb ? load_val_ma : alu_out_wb` (combinational)

## Operation
- Each stage carries a valid bit. A bubble clears valid, `ctl`, `reg_we`, `mem_re` and `jump` to 0. Data fields are don't-care but are zeroed.
- The hazard match against stage S on source `rsN` is `valid_S & reg_we_S & dst_S==rsN_id & rsN_used_id`.
- ID/EX capture bypass (always present): if `reg_we_wb` and `dst_reg_wb==rsN_id`, ID/EX latches `data_wb` instead of `rN_val_id`. This covers the same-cycle regfile write/read.
- Load-use: a match against EX or MA where that stage has `mem_re=1` raises stall. This gives up to 2 stall cycles.
- Stall response:
  - `pc_hold=1`.
  - IF/ID holds.
  - ID/EX captures a bubble.
  - EX/MA and MA/WB advance.
- Jump: while `jump_flag_ma=1`:
  - the next edge bubbles IF/ID, ID/EX and EX/MA;
  - `pc_hold=0`;
  - fetch loads `jump_addr_ma`.
- Flush has priority over stall.
- Priority of any stage register: `sys_rst` > flush > stall > advance.

## Timing
- Reset: every register and valid bit is 0. Every registered output is 0. `pc_hold=0`, `r1_ex=r2_ex=0`, `data_wb=0`.
- Boundary latency is 1 cycle per stage; IF to WB is 4 edges.
- Jump penalty is 3 cycles: the three wrong-path slots are bubbled.
- Reset mid-stall or mid-flush: all stages become bubbles on the next edge and `pc_hold` drops the same cycle.
- Stall and jump in the same cycle: the jump wins and the stalled instruction is discarded.

## Configuration
- `PIPE_FWD_EN` defined: `r1_ex`/`r2_ex` forward with priority MA then WB.
  - The MA source is `alu_out_ma` and requires `!mem_re_ma`.
  - The WB source is `data_wb`.
  - Otherwise the ID/EX register value is used.
  - Only load-use stalls occur.
- `PIPE_FWD_EN` undefined: `r1_ex`/`r2_ex` are the ID/EX register values.
  - Any match against EX or MA stalls, whether or not the producer is a load.
  - Worst-case RAW costs 2 stall cycles.

## Test plan
- Reset held for 2 cycles with random inputs → all outputs 0 and `pc_hold=0`. After release, `inst_if=0x5A` appears on `inst_id` 1 edge later.
- ADD r1←0x03, then ADD r2←r1+r1 back-to-back:
  - with FWD: `r1_ex=0x03` from MA, no stall;
  - without FWD: 2 cycles of `pc_hold=1`, then `r1_ex=0x03`.
- LOAD r2←mem (value 0x7F) followed by a use of r2 → exactly 2 stall cycles. `r1_ex=0x7F` via WB path in both configs.
- Taken jump to 0x9 → `jump_flag_ma=1` for 1 cycle. The next 3 ID/EX/MA slots are bubbles with `reg_we=0`, and `inst_addr_id=0x9` after the redirect.
- Load-use stall coinciding with `jump_flag_ma=1` → no hold, flush applied, the stalled instruction never reaches EX.
- Use of r3 while WB writes r3=0xC4 in the same cycle, with `r1_val_id` stale 0x00 → ID/EX captures 0xC4.
